mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W: instruction-fetch requester, read-only.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_wstrb in DATA_W/8, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W: load/store requester.
REQ-007 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_wstrb out DATA_W/8, mem_ready in 1, mem_rdata in DATA_W: shared single-port memory.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D.
REQ-009 In IDLE, SHALL drive if_gnt/d_gnt combinationally, at most one high, to the arbitration winner among asserted requests.
REQ-010 A request is accepted on the edge where req&&gnt; the arbiter SHALL latch addr/we/wdata/wstrb then and enter BUSY_IF or BUSY_D.
REQ-011 In BUSY_*, SHALL hold mem_req=1 with latched fields stable until the cycle mem_ready=1; both gnt SHALL be 0.
REQ-012 On the mem_ready cycle, SHALL register mem_rdata and pulse owner's rvalid for exactly one cycle on the next cycle; return to IDLE on that same edge.
REQ-013 For stores, d_rvalid SHALL pulse as completion with d_rdata=0; mem_we=0 and mem_wstrb=0 for all fetches.
REQ-014 Minimum transaction spacing SHALL be: accept cycle, >=1 busy cycle; new grant possible in the cycle rvalid pulses.
REQ-015 if_rdata/d_rdata SHALL hold last registered value until the next completion for that port.
REQ-016 mem_ready while IDLE SHALL be ignored (no rvalid, no state change).
REQ-017 A requester deasserting req before grant SHALL have no effect; req changes during BUSY SHALL not alter latched fields.
REQ-018 mem_req SHALL be 0 in IDLE; mem_addr/mem_wdata SHALL be 0 when mem_req=0.
REQ-019 Fixed priority (macro absent): on simultaneous if_req and d_req, d wins.

Reset
REQ-020 Asserting rst SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, both rvalid=0, both rdata=0, priority pointer to data.
REQ-021 Reset mid-transaction SHALL abort it with no rvalid pulse, even if mem_ready arrives during or after reset.
REQ-022 First grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-023 With MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate: winner is the port not granted most recently; pointer updates on each accept.
REQ-024 Without MEM_ARB_RR_EN, SHALL use fixed data priority per REQ-019 and contain no pointer register.

Verification
REQ-025 Single fetch: if_req=1, if_addr=0x10, mem_ready after 2 busy cycles with mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_rvalid one-cycle pulse, if_rdata=0x00500093.
REQ-026 Store: d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_we=1, mem_addr=0x8, mem_wdata=0xDEADBEEF, d_rvalid pulse, d_rdata=0.
REQ-027 Contention, macro absent: both req held for 4 transactions -> grants D,D,D,D; if starved; with MEM_ARB_RR_EN -> D,IF,D,IF.
REQ-028 Reset mid-transaction: rst pulse during BUSY_D, then mem_ready=1 -> no d_rvalid, mem_req=0, state IDLE.
REQ-029 Spurious mem_ready=1 in IDLE with no requests -> no rvalid, mem_req stays 0.
REQ-030 Back-to-back: if_req held, mem_ready each busy cycle -> new if_gnt in same cycle as prior if_rvalid; addresses 0x0,0x4,0x8 issued in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port memory between an instruction-fetch requester (IF,
//   read-only) and a load/store requester (D). One transaction is in flight at
//   a time. In IDLE a combinational grant picks a winner. The accepted request
//   is latched, and the memory port is driven from the latched copy until the
//   memory returns mem_ready. The returned data is registered, and the owner's
//   rvalid is pulsed for one cycle on the following cycle.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin between IF and D on contention
//                                (the port not granted most recently wins).
//                  undefined -> fixed priority, D always wins on contention.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request in
//   if_gnt/if_rvalid/if_rdata      fetch grant, completion pulse, read data out
//   d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request in
//   d_gnt/d_rvalid/d_rdata         load/store grant, completion pulse, data out
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory command out
//   mem_ready/mem_rdata            memory completion and read data in
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;

    logic [1:0]          state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                we_q,        we_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [DATA_W/8-1:0] wstrb_q,     wstrb_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

    logic idle;
    logic d_wins;

    assign idle = (state_q == IDLE);

`ifdef MEM_ARB_RR_EN
    // ptr_q = 1: D has priority on the next contention; 0: IF has priority.
    logic ptr_q, ptr_d;

    assign d_wins = d_req && (!if_req || ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (d_gnt) begin
            ptr_d = 1'b0;
        end else if (if_gnt) begin
            ptr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign d_wins = d_req;
`endif

    // Grants exist only in IDLE, and at most one is high.
    assign d_gnt  = idle && d_wins;
    assign if_gnt = idle && if_req && !d_wins;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                // mem_ready is ignored here.
                if (d_gnt) begin
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    // A load carries no byte enables onto the memory port.
                    wstrb_d = d_we ? d_wstrb : '0;
                    state_d = BUSY_D;
                end else if (if_gnt) begin
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_rdata_d  = mem_rdata;
                    if_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    // A store completes with zero read data.
                    d_rdata_d  = we_q ? '0 : mem_rdata;
                    d_rvalid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // The memory command is gated so that every field reads zero in IDLE.
    assign mem_req   = !idle;
    assign mem_we    = !idle && we_q;
    assign mem_addr  = idle ? '0 : addr_q;
    assign mem_wdata = idle ? '0 : wdata_q;
    assign mem_wstrb = idle ? '0 : wstrb_q;

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_d;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // ---------------- reset state ----------------
        #12;
        chk1 ("rst_mem_req",   mem_req,   1'b0);
        chk1 ("rst_mem_we",    mem_we,    1'b0);
        chk32("rst_mem_addr",  mem_addr,  32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk1 ("rst_if_rvalid", if_rvalid, 1'b0);
        chk1 ("rst_d_rvalid",  d_rvalid,  1'b0);
        chk32("rst_if_rdata",  if_rdata,  32'h0);
        chk32("rst_d_rdata",   d_rdata,   32'h0);
        rst = 1'b0;
        $display("reset released");
        tick();

        // ---------------- single fetch ----------------
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk1("fetch_if_gnt", if_gnt, 1'b1);
        chk1("fetch_d_gnt",  d_gnt,  1'b0);
        chk1("fetch_idle_mem_req", mem_req, 1'b0);
        tick();
        if_req = 1'b0; if_addr = 32'hFF;
        #1;
        chk1 ("fetch_busy_mem_req", mem_req, 1'b1);
        chk32("fetch_mem_addr", mem_addr, 32'h10);
        chk1 ("fetch_mem_we", mem_we, 1'b0);
        chk32("fetch_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk1 ("fetch_busy_if_gnt", if_gnt, 1'b0);
        tick();
        chk32("fetch_mem_addr_b2", mem_addr, 32'h10);
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        chk1 ("fetch_if_rvalid", if_rvalid, 1'b1);
        chk32("fetch_if_rdata", if_rdata, 32'h00500093);
        chk1 ("fetch_done_mem_req", mem_req, 1'b0);
        chk32("fetch_done_mem_addr", mem_addr, 32'h0);
        tick();
        chk1 ("fetch_if_rvalid_off", if_rvalid, 1'b0);
        chk32("fetch_if_rdata_hold", if_rdata, 32'h00500093);
        $display("single fetch done: if_rdata=%h", if_rdata);

        // ---------------- contention, 4 loads ----------------
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            chk1("cont_d_gnt",  d_gnt,  exp_d);
            chk1("cont_if_gnt", if_gnt, !exp_d);
            tick();
            chk32("cont_mem_addr", mem_addr, exp_d ? 32'h80 : 32'h40);
            mem_ready = 1'b1; mem_rdata = 32'h100 + 32'(i);
            tick();
            mem_ready = 1'b0;
            chk1("cont_d_rvalid",  d_rvalid,  exp_d);
            chk1("cont_if_rvalid", if_rvalid, !exp_d);
            if (exp_d) chk32("cont_d_rdata", d_rdata, 32'h100 + 32'(i));
            else       chk32("cont_if_rdata", if_rdata, 32'h100 + 32'(i));
            $display("contention txn %0d winner=%s", i, exp_d ? "D" : "IF");
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // ---------------- store ----------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        #1;
        chk1("store_d_gnt", d_gnt, 1'b1);
        tick();
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        #1;
        chk1 ("store_mem_we", mem_we, 1'b1);
        chk32("store_mem_addr", mem_addr, 32'h8);
        chk32("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk32("store_mem_wstrb", {28'h0, mem_wstrb}, 32'hF);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        chk1 ("store_d_rvalid", d_rvalid, 1'b1);
        chk32("store_d_rdata", d_rdata, 32'h0);
        chk1 ("store_if_rvalid", if_rvalid, 1'b0);
        tick();
        chk1 ("store_d_rvalid_off", d_rvalid, 1'b0);
        $display("store done: d_rdata=%h", d_rdata);

        // ---------------- reset mid-transaction ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        tick();
        d_req = 1'b0;
        chk1("rstmid_busy_mem_req", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1 ("rstmid_mem_req", mem_req, 1'b0);
        chk32("rstmid_mem_addr", mem_addr, 32'h0);
        chk32("rstmid_if_rdata", if_rdata, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        tick();
        rst = 1'b0;
        tick();
        chk1 ("rstmid_no_d_rvalid", d_rvalid, 1'b0);
        chk1 ("rstmid_mem_req_after", mem_req, 1'b0);
        tick();
        chk1 ("rstmid_no_d_rvalid2", d_rvalid, 1'b0);
        chk32("rstmid_d_rdata", d_rdata, 32'h0);
        mem_ready = 1'b0;
        $display("reset mid-transaction done");

        // ---------------- spurious mem_ready in IDLE ----------------
        mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
        tick();
        tick();
        chk1 ("spur_if_rvalid", if_rvalid, 1'b0);
        chk1 ("spur_d_rvalid",  d_rvalid,  1'b0);
        chk1 ("spur_mem_req",   mem_req,   1'b0);
        chk32("spur_if_rdata",  if_rdata,  32'h0);
        mem_ready = 1'b0;
        $display("spurious mem_ready done");

        // ---------------- back-to-back fetches ----------------
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        chk1("b2b_first_gnt", if_gnt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if_addr = 32'(4 * (i + 1));
            #1;
            chk32("b2b_mem_addr", mem_addr, 32'(4 * i));
            mem_ready = 1'b1; mem_rdata = 32'hC0 + 32'(i);
            tick();
            mem_ready = 1'b0;
            chk1 ("b2b_if_rvalid", if_rvalid, 1'b1);
            chk32("b2b_if_rdata", if_rdata, 32'hC0 + 32'(i));
            chk1 ("b2b_if_gnt_same_cycle", if_gnt, 1'b1);
            $display("b2b fetch %0d addr=%h rdata=%h", i, 32'(4 * i), if_rdata);
        end
        if_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
